// File: rtl/viterbi_stream_decoder.sv
// Streaming log-domain Viterbi decoder: per-observation forward recursion,
// single-cycle final argmax, one-step-per-cycle traceback, then in-order path output.
module viterbi_stream_decoder #(
   parameter int N = 16,
   parameter int I = 3,
   parameter int K = 3,
   parameter int W = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [$clog2(N+1)-1:0] length,
   input  logic [$clog2(K)-1:0]   obs_in,
   input  logic                   obs_valid,
   output logic                   obs_ready,
   input  logic signed [W-1:0]    logA [0:I-1][0:I-1],
   input  logic signed [W-1:0]    logC [0:I-1],
   input  logic signed [W-1:0]    logB [0:I-1][0:K-1],
   output logic [$clog2(I)-1:0]   path_state,
   output logic [$clog2(N)-1:0]   path_idx,
   output logic                   path_valid,
   input  logic                   path_ready,
   output logic signed [W-1:0]    best_score,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);
   localparam int LW = $clog2(N+1);
   localparam int IW = $clog2(N);
   localparam int SW = $clog2(I);
   localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FWD   = 3'd1;
   localparam logic [2:0] S_FINAL = 3'd2;
   localparam logic [2:0] S_BACK  = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

   logic [2:0]          state_q, state_d;
   logic [LW-1:0]       len_q, len_d;
   logic [LW-1:0]       t_q, t_d;
   logic [IW-1:0]       step_q, step_d;
   logic [IW-1:0]       outIdx_q, outIdx_d;
   logic signed [W-1:0] best_q, best_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic signed [W-1:0] delta_q [0:I-1];
   logic signed [W-1:0] delta_d [0:I-1];

   logic [SW-1:0]       psi_q [0:N-1][0:I-1];
   logic [SW-1:0]       path_q [0:N-1];

   logic signed [W-1:0] fwdBest [0:I-1];
   logic signed [W-1:0] fwdInit [0:I-1];
   logic signed [W-1:0] fwdStep [0:I-1];
   logic [SW-1:0]       fwdPsi [0:I-1];
   logic signed [W-1:0] cand;
   logic signed [W-1:0] finalScore;
   logic [SW-1:0]       finalIdx;
   logic [IW-1:0]       lastIdx;
   logic [IW-1:0]       tIdx;
   logic [IW-1:0]       stepM1;
   logic [SW-1:0]       backState;
   logic                accept;

   // Sum at W+1 bits; a disagreement between the top two bits means overflow.
   function automatic logic signed [W-1:0] sat(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
      logic signed [W:0] sum;
      sum = {a[W-1], a} + {b[W-1], b};
      if (sum[W] != sum[W-1]) begin
         return sum[W] ? SMIN : SMAX;
      end
      return sum[W-1:0];
   endfunction

   assign accept    = (state_q == S_FWD) && obs_valid;
   assign lastIdx   = IW'(len_q - LW'(1));
   assign tIdx      = IW'(t_q);
   assign stepM1    = step_q - IW'(1);
   assign backState = psi_q[step_q][path_q[step_q]];

   // Strict greater-than keeps the lowest predecessor index on ties.
   always_comb begin
      cand = '0;
      for (int j = 0; j < I; j++) begin
         fwdBest[j] = sat(delta_q[0], logA[0][j]);
         fwdPsi[j]  = '0;
         for (int i = 1; i < I; i++) begin
            cand = sat(delta_q[i], logA[i][j]);
            if (cand > fwdBest[j]) begin
               fwdBest[j] = cand;
               fwdPsi[j]  = SW'(i);
            end
         end
         fwdInit[j] = sat(logC[j], logB[j][obs_in]);
         fwdStep[j] = sat(fwdBest[j], logB[j][obs_in]);
      end
   end

   always_comb begin
      finalIdx   = '0;
      finalScore = delta_q[0];
      for (int i = 1; i < I; i++) begin
         if (delta_q[i] > finalScore) begin
            finalScore = delta_q[i];
            finalIdx   = SW'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      t_d      = t_q;
      step_d   = step_q;
      outIdx_d = outIdx_q;
      best_d   = best_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      for (int j = 0; j < I; j++) begin
         delta_d[j] = delta_q[j];
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (length == '0 || length > LW'(N)) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  state_d = S_FWD;
                  len_d   = length;
                  t_d     = '0;
               end
            end
         end
         S_FWD: begin
            if (obs_valid) begin
               for (int j = 0; j < I; j++) begin
                  delta_d[j] = (t_q == '0) ? fwdInit[j] : fwdStep[j];
               end
               t_d = t_q + LW'(1);
               if (t_d == len_q) begin
                  state_d = S_FINAL;
               end
            end
         end
         S_FINAL: begin
            best_d   = finalScore;
            outIdx_d = '0;
            step_d   = lastIdx;
            state_d  = (len_q == LW'(1)) ? S_OUT : S_BACK;
         end
         S_BACK: begin
            step_d = stepM1;
            if (step_q == IW'(1)) begin
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (path_ready) begin
               if (outIdx_q == lastIdx) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  outIdx_d = outIdx_q + IW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         t_q      <= '0;
         step_q   <= '0;
         outIdx_q <= '0;
         best_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         for (int j = 0; j < I; j++) begin
            delta_q[j] <= '0;
         end
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         t_q      <= t_d;
         step_q   <= step_d;
         outIdx_q <= outIdx_d;
         best_q   <= best_d;
         done_q   <= done_d;
         err_q    <= err_d;
         for (int j = 0; j < I; j++) begin
            delta_q[j] <= delta_d[j];
         end
      end
   end

   // Survivor and path memories are fully rewritten by each decode before use.
   always_ff @(posedge clk) begin
      if (accept && t_q != '0) begin
         for (int j = 0; j < I; j++) begin
            psi_q[tIdx][j] <= fwdPsi[j];
         end
      end
      if (state_q == S_FINAL) begin
         path_q[lastIdx] <= finalIdx;
      end
      if (state_q == S_BACK) begin
         path_q[stepM1] <= backState;
      end
   end

   assign obs_ready  = (state_q == S_FWD);
   assign path_valid = (state_q == S_OUT);
   assign busy       = (state_q != S_IDLE);
   assign path_state = (state_q == S_OUT) ? path_q[outIdx_q] : '0;
   assign path_idx   = outIdx_q;
   assign best_score = best_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule
